// File: rtl/network_idle_monitor.sv
// network_idle_monitor
// Starts a dataflow network through per-actor triggers and watches for the
// whole network to go quiet. Every trigger has to acknowledge its start,
// and then the network has to stay quiet for QUIET_CYCLES cycles in a row.
// After that, network_idle is broadcast so the triggers can drain. The run
// completes once every trigger reports ap_idle.
module network_idle_monitor #(
    parameter int NUM_TRIGGERS = 4,
    parameter int NUM_FIFOS    = 4,
    parameter int QUIET_CYCLES = 8
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    ap_start,
    output logic                    ap_done,
    output logic                    ap_ready,
    output logic                    ap_idle,
    output logic [NUM_TRIGGERS-1:0] trigger_start,
    input  logic [NUM_TRIGGERS-1:0] trigger_idle,
    input  logic [NUM_TRIGGERS-1:0] trigger_sleeping,
    input  logic [NUM_FIFOS-1:0]    fifo_write,
    output logic                    network_idle,
    output logic [31:0]             run_cycles
);

    // The counter is wide enough to hold QUIET_CYCLES even though it only
    // reaches QUIET_CYCLES-1. This keeps QUIET_CYCLES=1 at a legal width.
    localparam int                 CNT_W    = $clog2(QUIET_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [31:0]        RC_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_QUIESCE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  r_state;
    logic [NUM_TRIGGERS-1:0] r_pending;
    logic [CNT_W-1:0]        r_quiet_cnt;
    logic [31:0]             r_run_cycles;
    logic                    r_ap_done;
    logic                    r_ap_idle;
    logic                    r_network_idle;

    logic w_quiet;
    logic w_launch;
    logic w_counting;

    // Quiet means: every actor is asleep, no token moved this cycle, and no
    // trigger is still waiting to see its start.
    assign w_quiet    = (&trigger_sleeping) & ~(|fifo_write) & ~(|r_pending);
    assign w_launch   = (r_state == S_IDLE) & ap_start;
    assign w_counting = (r_state == S_RUN) | (r_state == S_QUIESCE) |
                        (r_state == S_DRAIN);

    // Run-control FSM. The status outputs are registered alongside the state
    // so that no input can reach them combinationally.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state        <= S_IDLE;
            r_quiet_cnt    <= '0;
            r_ap_done      <= 1'b0;
            r_ap_idle      <= 1'b1;
            r_network_idle <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_state   <= S_RUN;
                        r_ap_idle <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_quiet) begin
                        r_state     <= S_QUIESCE;
                        r_quiet_cnt <= '0;
                    end
                end
                S_QUIESCE: begin
                    // Any activity, including activity on the terminal
                    // count, restarts the wait from RUN.
                    if (!w_quiet) begin
                        r_state     <= S_RUN;
                        r_quiet_cnt <= '0;
                    end else if (r_quiet_cnt == CNT_LAST) begin
                        r_state        <= S_DRAIN;
                        r_network_idle <= 1'b1;
                    end else begin
                        r_quiet_cnt <= r_quiet_cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (&trigger_idle) begin
                        r_state        <= S_DONE;
                        r_network_idle <= 1'b0;
                        r_ap_done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_ap_done <= 1'b0;
                    r_ap_idle <= 1'b1;
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_quiet_cnt    <= '0;
                    r_ap_done      <= 1'b0;
                    r_ap_idle      <= 1'b1;
                    r_network_idle <= 1'b0;
                end
            endcase
        end
    end

    // Pending starts: all bits are armed at launch. Each bit drops on its
    // own as soon as its trigger is seen leaving idle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_pending <= '0;
        end else if (w_launch) begin
            r_pending <= '1;
        end else begin
            r_pending <= r_pending & trigger_idle;
        end
    end

    // Run length counter. It saturates rather than wrapping, so a very long
    // run is never mistaken for a short one.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_run_cycles <= '0;
        end else if (w_launch) begin
            r_run_cycles <= '0;
        end else if (w_counting && (r_run_cycles != RC_MAX)) begin
            r_run_cycles <= r_run_cycles + 32'd1;
        end
    end

    assign ap_done       = r_ap_done;
    assign ap_ready      = r_ap_done;
    assign ap_idle       = r_ap_idle;
    assign network_idle  = r_network_idle;
    assign trigger_start = r_pending;
    assign run_cycles    = r_run_cycles;

endmodule

// File: tb/tb_network_idle_monitor.sv
// Bench for network_idle_monitor with 2 triggers, 2 FIFOs and QUIET_CYCLES=4.
// Expected outputs come from a hand-built vector table and from a reference
// model. The model tracks a run phase and a count of consecutive quiet cycles.
module tb_network_idle_monitor;

    localparam int NT = 2;
    localparam int NF = 2;
    localparam int QC = 4;
    localparam int W  = 4 + NT + 32;

    localparam int PH_IDLE   = 0;
    localparam int PH_ACTIVE = 1;
    localparam int PH_DRAIN  = 2;
    localparam int PH_DONE   = 3;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_done;
    logic          ap_ready;
    logic          ap_idle;
    logic [NT-1:0] trigger_start;
    logic [NT-1:0] trigger_idle;
    logic [NT-1:0] trigger_sleeping;
    logic [NF-1:0] fifo_write;
    logic          network_idle;
    logic [31:0]   run_cycles;

    network_idle_monitor #(
        .NUM_TRIGGERS(NT),
        .NUM_FIFOS   (NF),
        .QUIET_CYCLES(QC)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_ready        (ap_ready),
        .ap_idle         (ap_idle),
        .trigger_start   (trigger_start),
        .trigger_idle    (trigger_idle),
        .trigger_sleeping(trigger_sleeping),
        .fifo_write      (fifo_write),
        .network_idle    (network_idle),
        .run_cycles      (run_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state.
    int          m_phase;
    int          m_streak;
    logic [NT-1:0] m_pending;
    logic [31:0] m_cycles;
    int          dut_runs;
    int          model_runs;
    logic        prev_done;

    wire [W-1:0] dut_vec = {ap_idle, ap_done, ap_ready, network_idle, trigger_start, run_cycles};

    typedef struct {
        logic          start;
        logic [NT-1:0] ti;
        logic [NT-1:0] sl;
        logic [NF-1:0] fw;
        logic          e_idle;
        logic          e_done;
        logic          e_nidle;
        logic [NT-1:0] e_ts;
        logic [31:0]   e_rc;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [W-1:0] model_vec();
        return {m_phase == PH_IDLE, m_phase == PH_DONE, m_phase == PH_DONE,
                m_phase == PH_DRAIN, m_pending, m_cycles};
    endfunction

    task automatic model_reset();
        m_phase   = PH_IDLE;
        m_streak  = 0;
        m_pending = '0;
        m_cycles  = '0;
    endtask

    // A run is active until QC+1 consecutive quiet cycles have been seen
    // (one to notice, QC to confirm). Then it drains until every trigger is
    // idle, and takes one done cycle before returning to idle.
    task automatic model_edge(input logic s, input logic [NT-1:0] ti,
                              input logic [NT-1:0] sl, input logic [NF-1:0] fw);
        bit            quiet;
        logic [NT-1:0] pend_next;
        quiet     = (&sl) && (fw == '0) && (m_pending == '0);
        pend_next = m_pending & ti;
        case (m_phase)
            PH_IDLE: if (s) begin
                m_phase   = PH_ACTIVE;
                pend_next = '1;
                m_cycles  = '0;
                m_streak  = 0;
            end
            PH_ACTIVE: begin
                if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
                m_streak = quiet ? m_streak + 1 : 0;
                if (m_streak == QC + 1) m_phase = PH_DRAIN;
            end
            PH_DRAIN: begin
                if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
                if (&ti) m_phase = PH_DONE;
            end
            default: m_phase = PH_IDLE;
        endcase
        m_pending = pend_next;
    endtask

    task automatic check(input string name, input logic [W-1:0] exp);
        logic [W-1:0] act;
        act   = dut_vec;
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got idle=%b done=%b ready=%b nidle=%b ts=%b rc=%h, want idle=%b done=%b ready=%b nidle=%b ts=%b rc=%h",
                     name, act[W-1], act[W-2], act[W-3], act[W-4], act[32 +: NT], act[31:0],
                     exp[W-1], exp[W-2], exp[W-3], exp[W-4], exp[32 +: NT], exp[31:0]);
        end
    endtask

    task automatic expect_int(input string name, input longint act, input longint exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Sample at the falling edge and compare against the model. Also count
    // done pulses, and flag any done that lasts longer than one cycle.
    task automatic tick_check(input string name);
        @(negedge ap_clk);
        check(name, model_vec());
        if (ap_done === 1'b1) dut_runs = dut_runs + 1;
        if (m_phase == PH_DONE) begin
            model_runs = model_runs + 1;
            $display("  %s: run complete, run_cycles=%0d", name, m_cycles);
        end
        if (prev_done === 1'b1 && ap_done === 1'b1)
            expect_int({name, "_done_width"}, 2, 1);
        prev_done = ap_done;
    endtask

    task automatic drive_edge(input logic s, input logic [NT-1:0] ti,
                              input logic [NT-1:0] sl, input logic [NF-1:0] fw);
        ap_start         = s;
        trigger_idle     = ti;
        trigger_sleeping = sl;
        fifo_write       = fw;
        @(posedge ap_clk);
        model_edge(s, ti, sl, fw);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n         = 1'b0;
        ap_start         = 1'b0;
        trigger_idle     = '1;
        trigger_sleeping = '0;
        fifo_write       = '0;
        model_reset();
        prev_done = 1'b0;
        #1;
        check("reset_values", {1'b1, 1'b0, 1'b0, 1'b0, {NT{1'b0}}, 32'd0});
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    // Input pattern for the baseline run: start, acknowledge at cycle 2,
    // asleep from cycle 3, all triggers idle from cycle 9.
    function automatic logic [NT-1:0] base_ti(input int k);
        return (k < 2 || k >= 9) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [NT-1:0] base_sl(input int k);
        return (k >= 3) ? 2'b11 : 2'b00;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NT-1:0] rti, rsl;
        logic [NF-1:0] rfw;
        logic          rst;

        //           start ti     sl     fw     idle  done  nidle ts     rc
        tbl[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0};
        tbl[1]  = '{1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'd0};
        tbl[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'd1};
        tbl[3]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd2};
        tbl[4]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd3};
        tbl[5]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd4};
        tbl[6]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd5};
        tbl[7]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 32'd6};
        tbl[8]  = '{1'b0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 32'd7};
        tbl[9]  = '{1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 32'd8};
        tbl[10] = '{1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 32'd9};
        tbl[11] = '{1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 32'd9};

        dut_runs   = 0;
        model_runs = 0;
        ap_rst_n   = 1'b0;
        do_reset();

        // Baseline run from the vector table.
        for (int i = 0; i < 12; i++) begin
            @(negedge ap_clk);
            check($sformatf("table_cyc%0d", i),
                  {tbl[i].e_idle, tbl[i].e_done, tbl[i].e_done, tbl[i].e_nidle,
                   tbl[i].e_ts, tbl[i].e_rc});
            $display("  table cyc%0d start=%b ti=%b sl=%b fw=%b -> idle=%b done=%b nidle=%b ts=%b rc=%0d",
                     i, tbl[i].start, tbl[i].ti, tbl[i].sl, tbl[i].fw,
                     ap_idle, ap_done, network_idle, trigger_start, run_cycles);
            drive_edge(tbl[i].start, tbl[i].ti, tbl[i].sl, tbl[i].fw);
        end

        // A FIFO write during QUIESCE restarts the quiet wait.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            tick_check($sformatf("fifo_pulse_cyc%0d", k));
            if (k == 10) expect_int("fifo_pulse_delays_drain", network_idle, 0);
            drive_edge(k == 0, (k < 2 || k >= 13) ? 2'b11 : 2'b00, base_sl(k),
                       (k == 6) ? 2'b01 : 2'b00);
        end

        // Trigger 1 acknowledges late; its pending bit clears on its own.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tick_check($sformatf("late_ack_cyc%0d", k));
            if (k == 3) expect_int("late_ack_ts_cyc3", trigger_start, 2);
            if (k == 5) expect_int("late_ack_ts_cyc5", trigger_start, 2);
            if (k == 6) expect_int("late_ack_ts_cyc6", trigger_start, 0);
            drive_edge(k == 0,
                       (k < 2) ? 2'b11 : (k < 5) ? 2'b10 : (k >= 12) ? 2'b11 : 2'b00,
                       base_sl(k), 2'b00);
        end

        // ap_start held high: at most one done per run, and no queued restart.
        do_reset();
        dut_runs   = 0;
        model_runs = 0;
        for (int k = 0; k < 40; k++) begin
            tick_check($sformatf("start_held_cyc%0d", k));
            drive_edge(1'b1, (k % 3 == 2) ? 2'b00 : 2'b11, 2'b11, 2'b00);
        end
        expect_int("start_held_done_count", dut_runs, model_runs);

        // Asynchronous reset during QUIESCE, between clock edges.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick_check($sformatf("abort_cyc%0d", k));
            drive_edge(k == 0, base_ti(k), base_sl(k), 2'b00);
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("async_reset_before_edge", {1'b1, 1'b0, 1'b0, 1'b0, {NT{1'b0}}, 32'd0});
        model_reset();
        @(negedge ap_clk);
        check("async_reset_held", {1'b1, 1'b0, 1'b0, 1'b0, {NT{1'b0}}, 32'd0});
        ap_rst_n  = 1'b1;
        prev_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick_check($sformatf("after_abort_cyc%0d", k));
            drive_edge(k == 0, base_ti(k), base_sl(k), 2'b00);
        end

        // Saturation: preload the counter close to its limit during a busy run.
        do_reset();
        for (int k = 0; k < 18; k++) begin
            tick_check($sformatf("saturate_cyc%0d", k));
            if (k == 8)  expect_int("saturate_hold", run_cycles, 64'hFFFF_FFFF);
            if (k == 17) expect_int("saturate_after_run", run_cycles, 64'hFFFF_FFFF);
            drive_edge(k == 0, (k == 0 || k >= 9) ? 2'b11 : 2'b00,
                       (k >= 9) ? 2'b11 : 2'b00, 2'b00);
            if (k == 2) begin
                #1;
                force dut.r_run_cycles = 32'hFFFF_FFFC;
                #1;
                release dut.r_run_cycles;
                m_cycles = 32'hFFFF_FFFC;
            end
        end

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        dut_runs   = 0;
        model_runs = 0;
        for (int k = 0; k < 1500; k++) begin
            tick_check("rand");
            for (int b = 0; b < NT; b++) begin
                rti[b] = ($urandom_range(3) != 0);
                rsl[b] = ($urandom_range(7) != 0);
            end
            for (int b = 0; b < NF; b++) rfw[b] = ($urandom_range(15) == 0);
            rst = ($urandom_range(3) == 0);
            drive_edge(rst, rti, rsl, rfw);
        end
        expect_int("rand_done_count", dut_runs, model_runs);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
